// File: rtl/waveform_generator_if.sv
// Control/data bundle for waveform_generator: advance strobe, restart
// pulse, configuration inputs and waveform outputs.
interface waveform_generator_if #(
  parameter int N = 8
);
  logic         ena;
  logic         start;
  logic [1:0]   cfg_mode;
  logic [N-1:0] cfg_lo;
  logic [N-1:0] cfg_hi;
  logic [N-1:0] cfg_step;
  logic [N-1:0] out;
  logic         dir;
  logic         cycle_done;
  logic         err;

  // Controller side: drives strobes/config, observes waveform.
  modport master (
    output ena, start, cfg_mode, cfg_lo, cfg_hi, cfg_step,
    input  out, dir, cycle_done, err
  );

  // Generator side.
  modport slave (
    input  ena, start, cfg_mode, cfg_lo, cfg_hi, cfg_step,
    output out, dir, cycle_done, err
  );
endinterface

// File: rtl/waveform_generator.sv
// Multi-mode waveform generator: sawtooth up/down, triangle or square
// between programmable lo/hi bounds, advanced by an enable strobe.
// Configuration is captured into shadow registers on start only.
module waveform_generator #(
  parameter int N = 8
) (
  input  logic               clk,
  input  logic               rst,
  waveform_generator_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_UP    = 2'd1,
    ST_DOWN  = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    MODE_SAW_UP   = 2'd0,
    MODE_SAW_DOWN = 2'd1,
    MODE_TRIANGLE = 2'd2,
    MODE_SQUARE   = 2'd3
  } mode_t;

  localparam logic [N-1:0] ONE = N'(1);

  state_t       r_state;
  mode_t        r_mode;
  logic [N-1:0] r_lo;
  logic [N-1:0] r_hi;
  logic [N-1:0] r_step;
  logic [N-1:0] r_cnt;
  logic [N-1:0] r_out;
  logic         r_dir;
  logic         r_done;
  logic         r_err;

  logic [N:0]   w_out_plus;
  logic [N:0]   w_out_minus;
  logic [N:0]   w_hi_minus;
  logic [N:0]   w_lo_plus;
  logic [N-1:0] w_ramp_up;
  logic [N-1:0] w_ramp_dn;
  logic [N-1:0] w_turn_dn;
  logic [N-1:0] w_turn_up;
  logic [N-1:0] w_sq_last;
  logic         w_at_hi;
  logic         w_at_lo;
  logic         w_sq_wrap;

  // Clamped next-sample candidates; N+1-bit arithmetic so carry/borrow
  // is detected instead of wrapping.
  always_comb begin
    w_out_plus  = {1'b0, r_out} + {1'b0, r_step};
    w_out_minus = {1'b0, r_out} - {1'b0, r_step};
    w_hi_minus  = {1'b0, r_hi}  - {1'b0, r_step};
    w_lo_plus   = {1'b0, r_lo}  + {1'b0, r_step};

    w_ramp_up = (w_out_plus > {1'b0, r_hi}) ? r_hi : w_out_plus[N-1:0];
    w_turn_up = (w_lo_plus  > {1'b0, r_hi}) ? r_hi : w_lo_plus[N-1:0];

    w_ramp_dn = (w_out_minus[N] || (w_out_minus[N-1:0] < r_lo)) ? r_lo : w_out_minus[N-1:0];
    w_turn_dn = (w_hi_minus[N]  || (w_hi_minus[N-1:0]  < r_lo)) ? r_lo : w_hi_minus[N-1:0];

    // A zero half-period behaves as one enabled cycle per phase.
    w_sq_last = (r_step == '0) ? '0 : (r_step - ONE);
    w_sq_wrap = (r_cnt == w_sq_last);

    w_at_hi = (r_out == r_hi);
    w_at_lo = (r_out == r_lo);
  end

  // Waveform state machine: reset, then restart on start, then advance on ena.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_mode  <= MODE_SAW_UP;
      r_lo    <= '0;
      r_hi    <= '0;
      r_step  <= '0;
      r_cnt   <= '0;
      r_out   <= '0;
      r_dir   <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else if (bus.start) begin
      r_mode <= mode_t'(bus.cfg_mode);
      r_lo   <= bus.cfg_lo;
      r_hi   <= bus.cfg_hi;
      r_step <= bus.cfg_step;
      r_cnt  <= '0;
      r_done <= 1'b0;
      if (bus.cfg_lo >= bus.cfg_hi) begin
        r_err   <= 1'b1;
        r_out   <= bus.cfg_lo;
        r_dir   <= 1'b0;
        r_state <= ST_FAULT;
      end else begin
        r_err <= 1'b0;
        if (mode_t'(bus.cfg_mode) == MODE_SAW_DOWN) begin
          r_out   <= bus.cfg_hi;
          r_dir   <= 1'b1;
          r_state <= ST_DOWN;
        end else begin
          r_out   <= bus.cfg_lo;
          r_dir   <= 1'b0;
          r_state <= ST_UP;
        end
      end
    end else begin
      // Pulse lasts exactly one clock regardless of ena.
      r_done <= 1'b0;
      if (bus.ena) begin
        case (r_state)
          ST_UP: begin
            case (r_mode)
              // Square runs entirely in ST_UP; r_dir carries the phase.
              MODE_SQUARE: begin
                if (w_sq_wrap) begin
                  r_cnt <= '0;
                  if (r_dir) begin
                    r_out  <= r_lo;
                    r_dir  <= 1'b0;
                    r_done <= 1'b1;
                  end else begin
                    r_out <= r_hi;
                    r_dir <= 1'b1;
                  end
                end else begin
                  r_cnt <= r_cnt + ONE;
                end
              end
              MODE_TRIANGLE: begin
                if (w_at_hi) begin
                  r_state <= ST_DOWN;
                  r_dir   <= 1'b1;
                  r_out   <= w_turn_dn;
                end else begin
                  r_out <= w_ramp_up;
                end
              end
              default: begin
                if (w_at_hi) begin
                  r_out  <= r_lo;
                  r_done <= 1'b1;
                end else begin
                  r_out <= w_ramp_up;
                end
              end
            endcase
          end
          ST_DOWN: begin
            if (r_mode == MODE_TRIANGLE) begin
              if (w_at_lo) begin
                r_state <= ST_UP;
                r_dir   <= 1'b0;
                r_out   <= w_turn_up;
                r_done  <= 1'b1;
              end else begin
                r_out <= w_ramp_dn;
              end
            end else begin
              if (w_at_lo) begin
                r_out  <= r_hi;
                r_done <= 1'b1;
              end else begin
                r_out <= w_ramp_dn;
              end
            end
          end
          default: begin
            // IDLE and FAULT hold their outputs.
          end
        endcase
      end
    end
  end

  assign bus.out        = r_out;
  assign bus.dir        = r_dir;
  assign bus.cycle_done = r_done;
  assign bus.err        = r_err;

endmodule
